// File: rtl/serial_bus_arbiter_rr.sv
// N-master serial bus arbiter with round-robin or fixed priority, latched slave select,
// grant hold until done/abort/timeout and a mandatory turnaround cycle between grants.
module serial_bus_arbiter_rr #(
  parameter int NUM_MASTERS    = 4,
  parameter int SLAVE_LEN      = 2,
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int NUM_SLAVES    = 2 ** SLAVE_LEN,
  localparam int MID_LEN       = ($clog2(NUM_MASTERS) > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int CNT_LEN       = ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic                             clock,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [NUM_MASTERS-1:0]           m_req,
  input  logic [NUM_MASTERS*SLAVE_LEN-1:0] m_slave,
  input  logic [NUM_MASTERS-1:0]           m_done,
  input  logic [NUM_SLAVES-1:0]            s_ready,
  output logic [NUM_MASTERS-1:0]           grant,
  output logic [MID_LEN-1:0]               grant_id,
  output logic [NUM_SLAVES-1:0]            s_sel,
  output logic                             bus_busy,
  output logic [NUM_MASTERS-1:0]           m_busy,
  output logic                             timeout
);

  typedef enum logic [1:0] {IDLE, ADDR, ACTIVE, RELEASE} state_t;

  localparam logic [CNT_LEN-1:0] CNT_LAST =
    CNT_LEN'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_d;
  logic [MID_LEN-1:0]     grant_id_d;
  logic [NUM_SLAVES-1:0]  s_sel_d;
  logic                   timeout_d;
  logic [SLAVE_LEN-1:0]   slave_id_q, slave_id_d;
  logic [CNT_LEN-1:0]     counter_q, counter_d;
  logic [MID_LEN-1:0]     rr_ptr_q, rr_ptr_d;

  logic                   win_found;
  logic [MID_LEN-1:0]     win_id;
  logic [MID_LEN-1:0]     scan_idx;
  int                     scan_full;
  logic                   tmo_hit;
  logic                   go_release;

  logic [SLAVE_LEN-1:0]   slave_of [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_slave_unpack
    assign slave_of[g] = m_slave[g*SLAVE_LEN +: SLAVE_LEN];
  end

  // Winner search: fixed mode scans from 0, round-robin scans from rr_ptr with wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_full = 0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (PRIORITY_MODE != 0) begin
        scan_full = i;
      end else begin
        scan_full = int'(rr_ptr_q) + i;
        if (scan_full >= NUM_MASTERS) scan_full = scan_full - NUM_MASTERS;
      end
      scan_idx = MID_LEN'(scan_full);
      if (!win_found && m_req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (counter_q == CNT_LAST);
  assign bus_busy = (state_q == ADDR) || (state_q == ACTIVE);
  assign m_busy   = m_req & ~grant;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant;
    grant_id_d = grant_id;
    s_sel_d    = s_sel;
    slave_id_d = slave_id_q;
    counter_d  = counter_q;
    rr_ptr_d   = rr_ptr_q;
    timeout_d  = 1'b0;
    go_release = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && win_found) begin
          state_d    = ADDR;
          grant_d    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win_id;
          grant_id_d = win_id;
          slave_id_d = slave_of[win_id];
          s_sel_d    = {{(NUM_SLAVES-1){1'b0}}, 1'b1} << slave_of[win_id];
          counter_d  = '0;
        end
      end
      ADDR: begin
        if (s_ready[slave_id_q]) begin
          state_d = ACTIVE;
        end else if (tmo_hit) begin
          go_release = 1'b1;
          timeout_d  = 1'b1;
        end else begin
          counter_d = counter_q + CNT_LEN'(1);
        end
      end
      ACTIVE: begin
        if (m_done[grant_id] || !m_req[grant_id]) begin
          go_release = 1'b1;
        end else if (tmo_hit) begin
          go_release = 1'b1;
          timeout_d  = 1'b1;
        end else begin
          counter_d = counter_q + CNT_LEN'(1);
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The pointer advances while entering RELEASE, since grant_id is cleared at the same edge.
    if (go_release) begin
      state_d    = RELEASE;
      grant_d    = '0;
      grant_id_d = '0;
      s_sel_d    = '0;
      if (PRIORITY_MODE == 0) begin
        rr_ptr_d = (grant_id == MID_LEN'(NUM_MASTERS - 1)) ? '0 : grant_id + MID_LEN'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant      <= '0;
      grant_id   <= '0;
      s_sel      <= '0;
      timeout    <= 1'b0;
      slave_id_q <= '0;
      counter_q  <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant      <= grant_d;
      grant_id   <= grant_id_d;
      s_sel      <= s_sel_d;
      timeout    <= timeout_d;
      slave_id_q <= slave_id_d;
      counter_q  <= counter_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_serial_bus_arbiter_rr.sv
// Bench for serial_bus_arbiter_rr: a round-robin instance and a fixed-priority instance
// share stimulus; vector table for reset/single/RR order, hand sequences for the rest.
module tb_serial_bus_arbiter_rr;

  logic       clock = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] m_req;
  logic [7:0] m_slave;
  logic [3:0] m_done;
  logic [3:0] s_ready;

  logic [3:0] rr_grant, fx_grant;
  logic [1:0] rr_gid, fx_gid;
  logic [3:0] rr_ssel, fx_ssel;
  logic       rr_busy, fx_busy;
  logic [3:0] rr_mbusy, fx_mbusy;
  logic       rr_tmo, fx_tmo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  serial_bus_arbiter_rr #(.NUM_MASTERS(4), .SLAVE_LEN(2), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)) dut_rr (
    .clock(clock), .rst(rst), .enable(enable), .m_req(m_req), .m_slave(m_slave),
    .m_done(m_done), .s_ready(s_ready), .grant(rr_grant), .grant_id(rr_gid),
    .s_sel(rr_ssel), .bus_busy(rr_busy), .m_busy(rr_mbusy), .timeout(rr_tmo));

  serial_bus_arbiter_rr #(.NUM_MASTERS(4), .SLAVE_LEN(2), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(8)) dut_fx (
    .clock(clock), .rst(rst), .enable(enable), .m_req(m_req), .m_slave(m_slave),
    .m_done(m_done), .s_ready(s_ready), .grant(fx_grant), .grant_id(fx_gid),
    .s_sel(fx_ssel), .bus_busy(fx_busy), .m_busy(fx_mbusy), .timeout(fx_tmo));

  typedef struct {
    string      name;
    logic       rst;
    logic       enable;
    logic [3:0] req;
    logic [7:0] slv;
    logic [3:0] done;
    logic [3:0] rdy;
    logic [3:0] e_grant;
    logic [1:0] e_gid;
    logic [3:0] e_ssel;
    logic       e_busy;
    logic [3:0] e_mbusy;
    logic       e_tmo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic r, logic en, logic [3:0] req, logic [7:0] slv,
                              logic [3:0] done, logic [3:0] rdy, logic [3:0] g, logic [1:0] gid,
                              logic [3:0] ssel, logic busy, logic [3:0] mb, logic tmo);
    vec_t v;
    v.name = name; v.rst = r; v.enable = en; v.req = req; v.slv = slv; v.done = done; v.rdy = rdy;
    v.e_grant = g; v.e_gid = gid; v.e_ssel = ssel; v.e_busy = busy; v.e_mbusy = mb; v.e_tmo = tmo;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic en, input logic [3:0] req,
                               input logic [7:0] slv, input logic [3:0] done, input logic [3:0] rdy);
    @(negedge clock);
    rst = r; enable = en; m_req = req; m_slave = slv; m_done = done; s_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] fdone;
    int order [5];

    rst = 1'b0; enable = 1'b0; m_req = '0; m_slave = '0; m_done = '0; s_ready = '0;

    vecs.push_back(mk("reset",         0, 1, 4'b1111, 8'h00, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b1111, 0));
    vecs.push_back(mk("single_grant",  1, 1, 4'b0100, 8'h30, 4'b0000, 4'b1000, 4'b0100, 2, 4'b1000, 1, 4'b0000, 0));
    vecs.push_back(mk("single_active", 1, 1, 4'b0100, 8'h30, 4'b0000, 4'b1000, 4'b0100, 2, 4'b1000, 1, 4'b0000, 0));
    vecs.push_back(mk("single_done",   1, 1, 4'b0100, 8'h30, 4'b0100, 4'b1000, 4'b0000, 0, 4'b0000, 0, 4'b0100, 0));
    vecs.push_back(mk("single_idle",   1, 1, 4'b0000, 8'h30, 4'b0000, 4'b1000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
    vecs.push_back(mk("rr_reset",      0, 1, 4'b1111, 8'h00, 4'b0000, 4'b0001, 4'b0000, 0, 4'b0000, 0, 4'b1111, 0));
    order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << order[k];
      fdone = (k == 1) ? 4'b1000 : 4'b0000;
      vecs.push_back(mk("rr_grant",  1, 1, 4'b1111, 8'h00, 4'b0000, 4'b0001, g, 2'(order[k]), 4'b0001, 1, 4'b1111 & ~g, 0));
      vecs.push_back(mk("rr_active", 1, 1, 4'b1111, 8'h00, fdone,   4'b0001, g, 2'(order[k]), 4'b0001, 1, 4'b1111 & ~g, 0));
      if (k < 4) begin
        vecs.push_back(mk("rr_done", 1, 1, 4'b1111, 8'h00, g,       4'b0001, 4'b0000, 0, 4'b0000, 0, 4'b1111, 0));
        vecs.push_back(mk("rr_idle", 1, 1, 4'b1111, 8'h00, 4'b0000, 4'b0001, 4'b0000, 0, 4'b0000, 0, 4'b1111, 0));
      end
    end

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].enable, vecs[i].req, vecs[i].slv, vecs[i].done, vecs[i].rdy);
      tick();
      checkOutput({vecs[i].name, ".grant"},    rr_grant, vecs[i].e_grant);
      checkOutput({vecs[i].name, ".grant_id"}, rr_gid,   vecs[i].e_gid);
      checkOutput({vecs[i].name, ".s_sel"},    rr_ssel,  vecs[i].e_ssel);
      checkOutput({vecs[i].name, ".bus_busy"}, rr_busy,  vecs[i].e_busy);
      checkOutput({vecs[i].name, ".m_busy"},   rr_mbusy, vecs[i].e_mbusy);
      checkOutput({vecs[i].name, ".timeout"},  rr_tmo,   vecs[i].e_tmo);
    end

    // Fixed priority: master 1 always beats master 3.
    applyStimulus(0, 1, 4'b0000, 8'h00, 4'b0000, 4'b0000); tick();
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1, 1, 4'b1010, 8'h00, 4'b0000, 4'b0001); tick();
      checkOutput("fixed_grant",  fx_grant, 4'b0010);
      checkOutput("fixed_gid",    fx_gid,   2'd1);
      checkOutput("fixed_m_busy", fx_mbusy, 4'b1000);
      applyStimulus(1, 1, 4'b1010, 8'h00, 4'b0000, 4'b0001); tick();
      checkOutput("fixed_active", fx_grant, 4'b0010);
      applyStimulus(1, 1, 4'b1010, 8'h00, 4'b0010, 4'b0001); tick();
      checkOutput("fixed_release", fx_grant, 4'b0000);
      applyStimulus(1, 1, 4'b1010, 8'h00, 4'b0000, 4'b0001); tick();
      checkOutput("fixed_turnaround", fx_grant, 4'b0000);
    end

    // Timeout while the target slave never becomes ready.
    applyStimulus(0, 1, 4'b0000, 8'h00, 4'b0000, 4'b0000); tick();
    applyStimulus(1, 1, 4'b0001, 8'h02, 4'b0000, 4'b0000); tick();
    checkOutput("tmo_addr_grant", rr_grant, 4'b0001);
    checkOutput("tmo_addr_ssel",  rr_ssel,  4'b0100);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, 1, 4'b0001, 8'h02, 4'b0000, 4'b0000); tick();
      if (i < 8) begin
        checkOutput("tmo_addr_hold",    rr_grant, 4'b0001);
        checkOutput("tmo_addr_no_tmo",  rr_tmo,   1'b0);
      end else begin
        checkOutput("tmo_addr_pulse",   rr_tmo,   1'b1);
        checkOutput("tmo_addr_revoked", rr_grant, 4'b0000);
        checkOutput("tmo_addr_busy",    rr_busy,  1'b0);
      end
    end
    applyStimulus(1, 1, 4'b0000, 8'h02, 4'b0000, 4'b0000); tick();
    checkOutput("tmo_addr_one_cycle", rr_tmo, 1'b0);

    // ACTIVE expiry: one ADDR cycle, counter runs 0..7 in ACTIVE, expiry at edge 9 after grant.
    for (int mode = 0; mode < 2; mode++) begin
      applyStimulus(1, 1, 4'b0001, 8'h02, 4'b0000, 4'b0100); tick();
      checkOutput("tmo_act_grant", rr_grant, 4'b0001);
      for (int i = 1; i <= 8; i++) begin
        applyStimulus(1, 1, 4'b0001, 8'h02, 4'b0000, 4'b0100); tick();
        checkOutput("tmo_act_hold", rr_grant, 4'b0001);
        checkOutput("tmo_act_no_tmo", rr_tmo, 1'b0);
      end
      applyStimulus(1, 1, 4'b0001, 8'h02, (mode == 1) ? 4'b0001 : 4'b0000, 4'b0100); tick();
      checkOutput("tmo_act_revoked", rr_grant, 4'b0000);
      checkOutput((mode == 1) ? "done_beats_tmo" : "tmo_act_pulse", rr_tmo, (mode == 1) ? 1'b0 : 1'b1);
      applyStimulus(1, 1, 4'b0000, 8'h02, 4'b0000, 4'b0100); tick();
      checkOutput("tmo_act_cleared", rr_tmo, 1'b0);
    end

    // Abort by dropping the request while ACTIVE.
    applyStimulus(0, 1, 4'b0000, 8'h00, 4'b0000, 4'b0000); tick();
    applyStimulus(1, 1, 4'b0010, 8'h00, 4'b0000, 4'b0001); tick();
    checkOutput("abort_grant", rr_grant, 4'b0010);
    applyStimulus(1, 1, 4'b0010, 8'h00, 4'b0000, 4'b0001); tick();
    checkOutput("abort_active_busy", rr_busy, 1'b1);
    applyStimulus(1, 1, 4'b0000, 8'h00, 4'b0000, 4'b0001); tick();
    checkOutput("abort_grant_clr", rr_grant, 4'b0000);
    checkOutput("abort_ssel_clr",  rr_ssel,  4'b0000);
    checkOutput("abort_no_tmo",    rr_tmo,   1'b0);
    applyStimulus(1, 1, 4'b0000, 8'h00, 4'b0000, 4'b0001); tick();

    // Asynchronous reset mid-transaction, then RR must restart from master 0.
    applyStimulus(1, 1, 4'b0100, 8'h10, 4'b0000, 4'b0010); tick();
    checkOutput("rst_mid_grant", rr_grant, 4'b0100);
    checkOutput("rst_mid_ssel",  rr_ssel,  4'b0010);
    applyStimulus(1, 1, 4'b0100, 8'h10, 4'b0000, 4'b0010); tick();
    @(negedge clock);
    rst = 1'b0;
    #1;
    checkOutput("rst_async_grant", rr_grant, 4'b0000);
    checkOutput("rst_async_ssel",  rr_ssel,  4'b0000);
    checkOutput("rst_async_busy",  rr_busy,  1'b0);
    checkOutput("rst_async_mbusy", rr_mbusy, 4'b0100);
    tick();
    applyStimulus(1, 1, 4'b1111, 8'h00, 4'b0000, 4'b0001); tick();
    checkOutput("rst_rr_restart", rr_grant, 4'b0001);
    checkOutput("rst_rr_gid",     rr_gid,   2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
